// File: rtl/store_align_unit.sv
// store_align_unit
//   Converts CPU store requests (sb/sh/sw) into word-aligned memory writes.
//   Data is laned to the byte offset, byte enables are generated, and
//   misaligned or reserved requests are rejected without a memory access.
//   With RMW_EN=1, sb/sh go through a read-modify-write sequence for
//   word-only memories. With RMW_EN=0, the unit writes directly using mem_be.
//
// Ports
//   clk, rst              clock (rising edge) and async active-high reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_addr/data/op      byte address, rs2 value, op (00 sb, 01 sh, 10 sw)
//   mem_addr              word-aligned address during RD/MERGE/WR, else 0
//   mem_rd_en/mem_rdata   read strobe; rdata is valid the following cycle
//   mem_wr_en/wdata/be    write strobe, write word, byte enables
//   done/err              retire pulse; err marks a rejected request
module store_align_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter bit          RMW_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] OP_SB = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       merged_q, merged_d;

  logic [3:0]        be_lane;
  logic [31:0]       laned;
  logic [31:0]       be_mask;
  logic              req_bad;
  logic              use_merge;
  logic [ADDR_W-1:0] word_addr;

  // Alignment check on the incoming request; only used to choose the
  // next state, never to drive outputs.
  always_comb begin
    req_bad = 1'b0;
    case (req_op)
      OP_SB:   req_bad = 1'b0;
      OP_SH:   req_bad = req_addr[0];
      OP_SW:   req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Laning and byte enables from the latched request.
  always_comb begin
    be_lane = '0;
    laned   = '0;
    case (op_q)
      OP_SB: begin
        be_lane = 4'b0001 << addr_q[1:0];
        laned   = 32'(data_q[7:0]) << {addr_q[1:0], 3'b000};
      end
      OP_SH: begin
        be_lane = addr_q[1] ? 4'b1100 : 4'b0011;
        laned   = addr_q[1] ? {data_q[15:0], 16'h0000} : {16'h0000, data_q[15:0]};
      end
      OP_SW: begin
        be_lane = '1;
        laned   = data_q;
      end
      default: begin
        be_lane = '0;
        laned   = '0;
      end
    endcase
  end

  assign be_mask   = {{8{be_lane[3]}}, {8{be_lane[2]}}, {8{be_lane[1]}}, {8{be_lane[0]}}};
  assign use_merge = RMW_EN && (op_q != OP_SW);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // State and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      op_q     <= op_d;
      merged_q <= merged_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    merged_d = merged_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_data;
          op_d   = req_op;
          if (req_bad)                        state_d = S_ERR;
          else if (req_op == OP_SW || !RMW_EN) state_d = S_WR;
          else                                 state_d = S_RD;
        end
      end
      S_RD:    state_d = S_MERGE;
      S_MERGE: begin
        // mem_rdata answers the read issued in RD during this cycle.
        merged_d = (mem_rdata & ~be_mask) | (laned & be_mask);
        state_d  = S_WR;
      end
      S_WR:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    mem_be    = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = 1'b1;
      S_RD: begin
        mem_addr  = word_addr;
        mem_rd_en = 1'b1;
      end
      S_MERGE: mem_addr = word_addr;
      S_WR: begin
        mem_addr  = word_addr;
        mem_wr_en = 1'b1;
        mem_wdata = use_merge ? merged_q : laned;
        mem_be    = be_lane;
        done      = 1'b1;
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule
